// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width, never allowed to collapse to zero bits.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_ha_cell.sv
// One-bit half adder; two of these plus an OR form the shared full-adder cell.
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first, one bit per clock,
// with valid/ready handshakes on operands and result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt;
    logic [CW-1:0]    cnt;
    logic             carry, cout_r;
    logic             s1, c1, fa_s, c2, fa_c;

    ha_cell u_ha1 (.x(a_sh[0]), .y(b_sh[0]), .s(s1),   .c(c1));
    ha_cell u_ha2 (.x(s1),      .y(carry),   .s(fa_s), .c(c2));
    assign fa_c = c1 | c2;

    // Written as shift-then-insert so WIDTH=1 needs no special case.
    always_comb begin
        sum_nxt            = sum_r >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= cin;
                    cnt   <= '0;
                    sum_r <= '0;
                    state <= RUN;
                end
                RUN: begin
                    carry <= fa_c;
                    sum_r <= sum_nxt;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout_r <= fa_c;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8 with hand-computed sums.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           t0, t1;
    logic [W-1:0] held_sum;
    logic         held_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        chk("in_ready_before_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk("busy_after_accept", busy, 1);
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, W);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);

        // Basic add
        accept(8'h5A, 8'h33, 1'b0);
        wait_result("basic", 8'h8D, 1'b0);
        release_result();

        // Full carry ripple
        accept(8'hFF, 8'h01, 1'b0);
        wait_result("ripple", 8'h00, 1'b1);
        release_result();

        // Carry-in, then backpressure while new operands wait
        accept(8'hFF, 8'hFF, 1'b1);
        wait_result("carry_in", 8'hFF, 1'b1);
        held_sum = sum; held_cout = cout;
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", sum, held_sum);
            chk("bp_cout", cout, held_cout);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("bp_accept_busy", busy, 1);
        wait_result("bp_new", 8'h46, 1'b0);
        release_result();

        // Reset mid-operation
        accept(8'h5A, 8'h33, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        step(); step();
        chk("midrst_no_valid", out_valid, 0);
        accept(8'h01, 8'h01, 1'b0);
        wait_result("after_rst", 8'h02, 1'b0);
        release_result();

        // Back-to-back with both handshakes held high
        out_ready = 1'b1;
        a = 8'h10; b = 8'h20; cin = 1'b0; in_valid = 1'b1;
        chk("b2b_first_ready", in_ready, 1);
        t0 = cyc;
        step();
        a = 8'h80; b = 8'h80;
        wait_result("b2b_first", 8'h30, 1'b0);
        step();
        chk("b2b_idle_ready", in_ready, 1);
        t1 = cyc;
        step();
        in_valid = 1'b0;
        chk("b2b_accept_spacing", t1 - t0, W + 2);
        chk("b2b_second_busy", busy, 1);
        wait_result("b2b_second", 8'h00, 1'b1);
        step();
        out_ready = 1'b0;
        chk("b2b_final_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that time-shares one full-adder cell across a WIDTH-bit addition, one bit per clock, LSB first.
- The full-adder cell is built from two half-adder cells and an OR on the carries.
- Operands enter on a valid/ready handshake; the result leaves on a valid/ready handshake.
- Sits between an operand producer and a result consumer as the low-area alternative to a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 1 or more.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents operands.
- in_ready  output  1  block can accept operands; high only in state IDLE.
- a  input  WIDTH  operand A; sampled only on the accept edge.
- b  input  WIDTH  operand B; sampled only on the accept edge.
- cin  input  1  carry-in; sampled only on the accept edge.
- out_valid  output  1  sum and cout hold a completed result; high only in state DONE.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  result bits (a + b + cin) modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous): rst high at an edge forces state IDLE, out_valid=0, busy=0, in_ready=1, sum=0, cout=0, bit counter=0, carry=0.
  - rst overrides every other input in the same cycle.
  - An operation in flight is abandoned and produces no out_valid.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid && in_ready: load shift registers a_sh=a, b_sh=b; carry=cin; bit counter=0; sum register=0; go to RUN.
- State RUN, one bit per edge:
  - Half adder 1: a_sh[0] and b_sh[0] give s1 and c1.
  - Half adder 2: s1 and carry give s and c2.
  - carry <= c1 | c2.
  - sum register shifts right, with s entering at the MSB.
  - a_sh and b_sh shift right.
  - Bit counter increments.
  - On the edge where bit counter == WIDTH-1: go to DONE, and cout <= c1 | c2.
- State DONE:
  - out_valid=1; sum and cout held stable.
  - On an edge with out_ready=1: go to IDLE.
  - in_valid is ignored; in_ready=0.
- Latency: out_valid is asserted exactly WIDTH clock cycles after the accept edge.
- Minimum spacing between accepts is WIDTH+2 cycles: WIDTH RUN cycles, at least one DONE cycle, and one IDLE cycle.
- Operand inputs may change freely after acceptance without affecting the result.
- sum and cout are only defined while out_valid=1. During RUN, sum shows partial shift contents and must not be checked.
- WIDTH=1: RUN lasts one cycle. The bit counter is sized to $clog2 of max(WIDTH,2) so it is never zero-width.
- in_ready, out_valid and busy are decoded combinationally from the state register only, with no input-to-output combinational path.

Decomposition:
- Shared package serial_adder_pkg holds:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- One sub-module, ha_cell: a 1-bit half adder with inputs x, y and outputs s = x^y, c = x&y.
  - Instantiated twice to form the per-bit full adder.
  - Everything else (FSM, counter, shift registers) stays in serial_adder_ctrl.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x33, cin=0.
  - Required: out_valid 8 cycles after accept, sum=0x8D, cout=0.
- Full carry ripple: a=0xFF, b=0x01, cin=0.
  - Required: sum=0x00, cout=1.
- Carry-in: a=0xFF, b=0xFF, cin=1.
  - Required: sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - Required: sum and cout stable, in_ready=0, no accept.
  - Raise out_ready: IDLE on the next edge and in_ready=1.
  - The new operands are accepted on the following edge.
- Reset mid-operation: assert rst for one cycle after 3 RUN cycles of 0x5A+0x33.
  - Required: next cycle state is IDLE, in_ready=1, out_valid=0, busy=0.
  - A following 0x01+0x01, cin=0 gives sum=0x02, cout=0.
- Back-to-back: in_valid held high and out_ready held high, operands 0x10+0x20 then 0x80+0x80.
  - Required: results 0x30/cout=0, then 0x00/cout=1.
  - Accept edges are exactly WIDTH+2 = 10 cycles apart.
